mem_io_cycle_fsm: RTL and testbench
===================================

# mem_io_cycle_fsm

Executes a single Z80 memory-read, memory-write, port-read or port-write machine cycle (MR/MRH/MRL, MW/MWH/MWL and stack variants, PR, PW) on the external bus, including WAIT_L stretching. It sits beside the opcode-fetch sequencer, directly downstream of the instruction decoder / control FSM. The control FSM dispatches one cycle at a time; this block drives the strobes and address/data, then returns read data and a done pulse.

## Interface
- No parameters.
- clk  in  1  system clock; one clock = one T-state.
- rst_L  in  1  reset, asynchronous, active-low.
- cyc_start  in  1  request a machine cycle; accepted only in IDLE or in T3.
- cyc_type  in  2  00 = MR, 01 = MW, 10 = PR, 11 = PW; latched on accept.
- cyc_addr  in  16  memory address, or port address in the low byte; latched on accept.
- cyc_wdata  in  8  write data for MW/PW; latched on accept.
- cyc_busy  out  1  high in T1, T2, TW and T3.
- cyc_done  out  1  one-cycle pulse during T3.
- cyc_rdata  out  8  data captured for MR/PR; holds until the next read capture.
- cyc_rdata_valid  out  1  one-cycle pulse in the cycle after a read's T3.
- data_in  in  8  external data bus, input side.
- WAIT_L  in  1  external wait request, sampled on the clock edge.
- addr_out  out  16  address bus.
- data_out  out  8  write data.
- data_oe  out  1  data_out drive enable.
- MREQ_L, IORQ_L, RD_L, WR_L  out  1 each  bus strobes, active-low.

## Operation
- States: IDLE, T1, T2, TW, T3. All outputs are decoded from the registered state plus the latched type/addr/wdata. No output depends combinationally on an input.
- IDLE: if cyc_start, latch type/addr/wdata and go to T1. Otherwise stay.
- T1 -> T2 unconditionally.
- T2, memory types: if WAIT_L = 0, go to TW; else go to T3.
- T2, port types: always go to TW. This is the automatic Z80 IO wait state.
- TW: if WAIT_L = 0, stay in TW; else go to T3.
- T3: if cyc_start, latch new request and go to T1 (back-to-back, no gap). Else go to IDLE.
- addr_out carries the latched address in T1 through T3, and 16'h0000 in IDLE. For ports, addr_out[15:8] = 8'h00.
- MR: MREQ_L and RD_L are low in T1, T2, TW and T3.
- MW: MREQ_L is low in T1 through T3. WR_L is low in T2, TW and T3. data_oe = 1 and data_out = wdata in T1 through T3.
- PR: IORQ_L and RD_L are low in T2, TW and T3.
- PW: IORQ_L and WR_L are low in T2, TW and T3. data_oe = 1 in T1 through T3.
- Read capture: on the clock edge leaving T3 of MR/PR, cyc_rdata <= data_in. cyc_rdata_valid = 1 for the following cycle. Writes never change cyc_rdata.
- cyc_start outside IDLE or T3 is ignored; the latched request is not disturbed.
- Reset (asynchronous, any state): state = IDLE, all strobes = 1, addr_out = 0, data_out = 0, data_oe = 0, cyc_busy = 0, cyc_done = 0, cyc_rdata = 8'h00, cyc_rdata_valid = 0. A cycle cut off by reset is abandoned with no done and no capture.

## Timing
- Accept edge to T1: 1 clock.
- MR/MW with no wait: 3 busy cycles. cyc_done is in cycle 3 after accept.
- PR/PW with no external wait: 4 busy cycles (T1, T2, TW, T3).
- Each clock with WAIT_L low at a T2 (memory) or TW sample adds one TW.
- Read data is valid on cyc_rdata in the cycle cyc_rdata_valid is high, one cycle after cyc_done.
- Back-to-back: a request accepted in T3 yields T1 on the next clock, so strobes stay continuous. MREQ_L stays low across MR -> MR.
- WAIT_L is ignored in T1, T3 and IDLE.

## Test plan
- Reset mid-MW: assert rst_L = 0 while in T2.
  - All strobes go high immediately, data_oe = 0, state is IDLE.
  - No cyc_done pulse.
- MR, addr 16'h1234, data_in = 8'hA5 at T3, WAIT_L = 1.
  - MREQ_L/RD_L low for exactly 3 cycles, addr_out = 16'h1234.
  - cyc_done in cycle 3.
  - Next cycle: cyc_rdata = 8'hA5 and cyc_rdata_valid = 1.
- MW, addr 16'hFFFE, wdata 8'h3C, WAIT_L low for 2 samples.
  - MREQ_L low 5 cycles; WR_L low 4 cycles; data_out = 8'h3C throughout.
  - cyc_done in cycle 5.
  - cyc_rdata unchanged.
- PR, addr 16'h00FE, data_in = 8'h7E, WAIT_L = 1.
  - IORQ_L/RD_L low in cycles 2–4; addr_out = 16'h00FE.
  - cyc_done in cycle 4; captured 8'h7E.
- Back-to-back: MR accepted, then PW (addr 8'h10, wdata 8'h55) requested in the MR's T3.
  - PW T1 follows immediately.
  - IORQ_L/WR_L low 3 cycles; two cyc_done pulses 4 cycles apart.
- Spurious cyc_start in T2 with different addr/type: ignored, and the current cycle completes unchanged.

Source files
------------

// File: rtl/mem_io_cycle_fsm.sv
// Z80 memory/IO machine-cycle sequencer: drives MREQ/IORQ/RD/WR, address and write data,
// stretches on WAIT_L, and returns captured read data with a done pulse.
module mem_io_cycle_fsm (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        cyc_start,
  input  logic [1:0]  cyc_type,
  input  logic [15:0] cyc_addr,
  input  logic [7:0]  cyc_wdata,
  output logic        cyc_busy,
  output logic        cyc_done,
  output logic [7:0]  cyc_rdata,
  output logic        cyc_rdata_valid,
  input  logic [7:0]  data_in,
  input  logic        WAIT_L,
  output logic [15:0] addr_out,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        MREQ_L,
  output logic        IORQ_L,
  output logic        RD_L,
  output logic        WR_L
);

  // state   | meaning
  // S_IDLE  | bus quiet, waiting for a request
  // S_T1    | address out; memory strobes asserted
  // S_T2    | read/write strobes; memory samples WAIT_L here
  // S_TW    | wait state (forced once for IO), repeats while WAIT_L low
  // S_T3    | data sampled; done pulse; may accept the next request
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TW   = 3'd3,
    S_T3   = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic [1:0]  type_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        rdata_valid_q;

  logic is_port, is_write, busy, strobe_win;

  assign is_port  = type_q[1];
  assign is_write = type_q[0];

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cyc_start) begin
          accept    = 1'b1;
          state_nxt = S_T1;
        end
      end
      S_T1: state_nxt = S_T2;
      S_T2: begin
        if (is_port || !WAIT_L) state_nxt = S_TW;
        else                    state_nxt = S_T3;
      end
      S_TW: begin
        if (WAIT_L) state_nxt = S_T3;
      end
      S_T3: begin
        if (cyc_start) begin
          accept    = 1'b1;
          state_nxt = S_T1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state         <= S_IDLE;
      type_q        <= 2'b00;
      addr_q        <= 16'h0000;
      wdata_q       <= 8'h00;
      rdata_q       <= 8'h00;
      rdata_valid_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      rdata_valid_q <= 1'b0;
      // Capture must use the outgoing cycle's type, before a back-to-back accept overwrites it.
      if (state == S_T3 && !is_write) begin
        rdata_q       <= data_in;
        rdata_valid_q <= 1'b1;
      end
      if (accept) begin
        type_q  <= cyc_type;
        addr_q  <= cyc_addr;
        wdata_q <= cyc_wdata;
      end
    end
  end

  assign busy       = (state != S_IDLE);
  assign strobe_win = (state == S_T2) || (state == S_TW) || (state == S_T3);

  assign cyc_busy        = busy;
  assign cyc_done        = (state == S_T3);
  assign cyc_rdata       = rdata_q;
  assign cyc_rdata_valid = rdata_valid_q;

  assign addr_out = !busy  ? 16'h0000 :
                    is_port ? {8'h00, addr_q[7:0]} : addr_q;
  assign data_oe  = busy && is_write;
  assign data_out = data_oe ? wdata_q : 8'h00;

  // IO strobes wait for T2; memory read strobes start in T1, memory write in T2.
  assign MREQ_L = !(busy && !is_port);
  assign IORQ_L = !(strobe_win && is_port);
  assign RD_L   = !(!is_write && (is_port ? strobe_win : busy));
  assign WR_L   = !(is_write && strobe_win);

endmodule

// File: tb/tb_mem_io_cycle_fsm.sv
// Bench for mem_io_cycle_fsm: directed plan scenarios plus random cycles, each busy cycle
// compared against expectations derived from cycle index, type and wait count.
module tb_mem_io_cycle_fsm;

  logic        clk;
  logic        rst_L;
  logic        cyc_start;
  logic [1:0]  cyc_type;
  logic [15:0] cyc_addr;
  logic [7:0]  cyc_wdata;
  logic        cyc_busy;
  logic        cyc_done;
  logic [7:0]  cyc_rdata;
  logic        cyc_rdata_valid;
  logic [7:0]  data_in;
  logic        WAIT_L;
  logic [15:0] addr_out;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        MREQ_L, IORQ_L, RD_L, WR_L;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_rdata;
  bit         pend_valid;

  mem_io_cycle_fsm dut (
    .clk(clk), .rst_L(rst_L),
    .cyc_start(cyc_start), .cyc_type(cyc_type), .cyc_addr(cyc_addr), .cyc_wdata(cyc_wdata),
    .cyc_busy(cyc_busy), .cyc_done(cyc_done), .cyc_rdata(cyc_rdata),
    .cyc_rdata_valid(cyc_rdata_valid), .data_in(data_in), .WAIT_L(WAIT_L),
    .addr_out(addr_out), .data_out(data_out), .data_oe(data_oe),
    .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {MREQ_L, IORQ_L, RD_L, WR_L};
  endfunction

  task automatic chk_read_side();
    chk("rdata_valid", cyc_rdata_valid, pend_valid);
    chk("rdata", cyc_rdata, exp_rdata);
    pend_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", cyc_busy, 1'b0);
      chk("idle_done", cyc_done, 1'b0);
      chk("idle_strobes", strobes(), 4'hF);
      chk("idle_addr", addr_out, 16'h0000);
      chk("idle_oe", data_oe, 1'b0);
      chk_read_side();
      cyc_start = 1'b0;
      WAIT_L    = 1'($urandom);
      data_in   = 8'($urandom);
    end
  endtask

  task automatic issue(input logic [1:0] t, input logic [15:0] a, input logic [7:0] w);
    cyc_start = 1'b1;
    cyc_type  = t;
    cyc_addr  = a;
    cyc_wdata = w;
  endtask

  // One accepted cycle. Busy length: 3 for memory, 4 for IO, plus one per low WAIT_L sample.
  task automatic body(input logic [1:0] t, input logic [15:0] a, input logic [7:0] w,
                      input int nw, input logic [7:0] rd, input bit spur,
                      input bit nv, input logic [1:0] nt, input logic [15:0] na,
                      input logic [7:0] nwd);
    bit port, wr;
    int n;
    logic [3:0]  es;
    logic [15:0] ea;
    port = t[1];
    wr   = t[0];
    n    = (port ? 4 : 3) + nw;
    ea   = port ? {8'h00, a[7:0]} : a;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      es[3] = !(!port);
      es[2] = !(port && k >= 2);
      es[1] = !(!wr && (port ? k >= 2 : 1'b1));
      es[0] = !(wr && k >= 2);
      chk("busy", cyc_busy, 1'b1);
      chk("done", cyc_done, k == n);
      chk("strobes", strobes(), es);
      chk("addr", addr_out, ea);
      chk("oe", data_oe, wr);
      if (wr) chk("data_out", data_out, w);
      chk_read_side();
      cyc_start = 1'b0;
      data_in   = (k == n) ? rd : 8'($urandom);
      if (!port && k >= 2 && k <= 2 + nw)      WAIT_L = (k <= 1 + nw) ? 1'b0 : 1'b1;
      else if (port && k >= 3 && k <= 3 + nw)  WAIT_L = (k <= 2 + nw) ? 1'b0 : 1'b1;
      else                                     WAIT_L = 1'($urandom);
      if (spur && k == 2) issue(~t, ~a, ~w);
      if (nv && k == n)   issue(nt, na, nwd);
    end
    if (!wr) begin
      exp_rdata  = rd;
      pend_valid = 1;
    end
  endtask

  initial begin
    rst_L      = 1'b0;
    cyc_start  = 1'b0;
    cyc_type   = 2'b00;
    cyc_addr   = 16'h0000;
    cyc_wdata  = 8'h00;
    data_in    = 8'h00;
    WAIT_L     = 1'b1;
    exp_rdata  = 8'h00;
    pend_valid = 0;

    #1;
    chk("rst_strobes", strobes(), 4'hF);
    chk("rst_busy", cyc_busy, 1'b0);
    chk("rst_addr", addr_out, 16'h0000);
    chk("rst_rdata", cyc_rdata, 8'h00);
    repeat (2) @(negedge clk);
    rst_L = 1'b1;
    idle(2);

    // Reset while in T2 of a write
    issue(2'b01, 16'hABCD, 8'h5A);
    @(negedge clk);
    cyc_start = 1'b0;
    @(negedge clk);
    chk("mw_t2_wr", WR_L, 1'b0);
    #2 rst_L = 1'b0;
    #1;
    chk("rstmid_strobes", strobes(), 4'hF);
    chk("rstmid_oe", data_oe, 1'b0);
    chk("rstmid_dout", data_out, 8'h00);
    chk("rstmid_busy", cyc_busy, 1'b0);
    chk("rstmid_done", cyc_done, 1'b0);
    chk("rstmid_addr", addr_out, 16'h0000);
    @(negedge clk);
    rst_L = 1'b1;
    idle(3);

    // MR 1234 / A5
    issue(2'b00, 16'h1234, 8'h00);
    body(2'b00, 16'h1234, 8'h00, 0, 8'hA5, 0, 0, 2'b00, 16'h0, 8'h0);
    idle(1);
    // MW FFFE / 3C with two wait samples
    issue(2'b01, 16'hFFFE, 8'h3C);
    body(2'b01, 16'hFFFE, 8'h3C, 2, 8'h00, 0, 0, 2'b00, 16'h0, 8'h0);
    idle(1);
    // PR 00FE / 7E
    issue(2'b10, 16'h00FE, 8'h00);
    body(2'b10, 16'h00FE, 8'h00, 0, 8'h7E, 0, 0, 2'b00, 16'h0, 8'h0);
    idle(1);
    // MR then PW 0010/55 requested in T3, then MR -> MR chain
    issue(2'b00, 16'h2000, 8'h00);
    body(2'b00, 16'h2000, 8'h00, 0, 8'h11, 0, 1, 2'b11, 16'h0010, 8'h55);
    body(2'b11, 16'h0010, 8'h55, 0, 8'h00, 0, 1, 2'b00, 16'h3000, 8'h00);
    body(2'b00, 16'h3000, 8'h00, 1, 8'h22, 0, 1, 2'b00, 16'h3001, 8'h00);
    body(2'b00, 16'h3001, 8'h00, 0, 8'h33, 0, 0, 2'b00, 16'h0, 8'h0);
    idle(1);
    // Spurious start in T2
    issue(2'b00, 16'h4321, 8'h00);
    body(2'b00, 16'h4321, 8'h00, 0, 8'h9C, 1, 0, 2'b00, 16'h0, 8'h0);
    idle(1);

    begin
      logic [1:0]  t, nt;
      logic [15:0] a, na;
      logic [7:0]  w, nwd;
      bit          chain;
      t = 2'($urandom); a = 16'($urandom); w = 8'($urandom);
      issue(t, a, w);
      for (int i = 0; i < 40; i++) begin
        nt = 2'($urandom); na = 16'($urandom); nwd = 8'($urandom);
        chain = (i < 39) && ($urandom_range(0, 1) == 1);
        body(t, a, w, $urandom_range(0, 3), 8'($urandom), $urandom_range(0, 3) == 0,
             chain, nt, na, nwd);
        if (!chain) begin
          idle($urandom_range(1, 3));
          if (i < 39) issue(nt, na, nwd);
        end
        t = nt; a = na; w = nwd;
      end
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
